// File: rtl/activation_pkg.sv
// rtl/activation_pkg.sv - shared mode encodings and default widths for the activation pipeline
package activation_pkg;

  typedef enum logic [1:0] {
    MODE_RELU  = 2'd0,
    MODE_CLAMP = 2'd1,
    MODE_LEAKY = 2'd2,
    MODE_RSVD  = 2'd3
  } act_mode_e;

  localparam int LEAKY_SHIFT = 3;

  localparam int DEF_IN_W    = 12;
  localparam int DEF_OUT_W   = 5;
  localparam int DEF_CH      = 4;
  localparam int DEF_SHIFT_W = 4;
  localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/activation_lane.sv
// rtl/activation_lane.sv - combinational shift, activation and clamp for one channel
module activation_lane
  import activation_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int SHIFT_W = DEF_SHIFT_W
) (
  input  logic signed [IN_W-1:0]    x,
  input  logic        [1:0]         mode,
  input  logic        [SHIFT_W-1:0] shift,
  output logic        [OUT_W-1:0]   y,
  output logic                      sat
);

  localparam logic signed [IN_W-1:0] U_MAX = IN_W'((1 << OUT_W) - 1);
  localparam logic signed [IN_W-1:0] S_MAX = IN_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] S_MIN = IN_W'(-(1 << (OUT_W - 1)));

  logic signed [IN_W-1:0] t;
  logic signed [IN_W-1:0] u;

  always_comb begin
    t   = '0;
    u   = '0;
    y   = '0;
    sat = 1'b0;
    // Large shifts collapse to the sign so the result never depends on shift-width overflow
    if (int'(shift) >= IN_W - 1) begin
      t = x[IN_W-1] ? '1 : '0;
    end else begin
      t = x >>> shift;
    end
    case (mode)
      MODE_CLAMP, MODE_LEAKY: begin
        u = (mode == MODE_LEAKY && t[IN_W-1]) ? (t >>> LEAKY_SHIFT) : t;
        if (u > S_MAX) begin
          y   = S_MAX[OUT_W-1:0];
          sat = 1'b1;
        end else if (u < S_MIN) begin
          y   = S_MIN[OUT_W-1:0];
          sat = 1'b1;
        end else begin
          y = u[OUT_W-1:0];
        end
      end
      default: begin
        if (t[IN_W-1]) begin
          y = '0;
        end else if (t > U_MAX) begin
          y   = U_MAX[OUT_W-1:0];
          sat = 1'b1;
        end else begin
          y = t[OUT_W-1:0];
        end
      end
    endcase
  end

endmodule

// File: rtl/activation_pipe.sv
// rtl/activation_pipe.sv - two-stage multi-channel activation with flow control and saturation counter
module activation_pipe
  import activation_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int CH      = DEF_CH,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CH*IN_W-1:0]    in_data,
  input  logic [1:0]            mode,
  input  logic [SHIFT_W-1:0]    shift,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH*OUT_W-1:0]   out_data,
  output logic [CH-1:0]         out_sat,
  output logic [CNT_W-1:0]      sat_count,
  input  logic                  clr_count
);

  localparam int POP_W = $clog2(CH + 1);

  logic                       s1_valid;
  logic [CH*IN_W-1:0]         s1_data;
  logic [1:0]                 s1_mode;
  logic [SHIFT_W-1:0]         s1_shift;
  logic                       s2_adv;
  logic [CH-1:0][OUT_W-1:0]   lane_y;
  logic [CH-1:0]              lane_sat;
  logic [POP_W-1:0]           sat_pop;
  logic [CNT_W:0]             cnt_sum;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  // Payload registers need no reset: s1_valid alone qualifies them
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_data  <= in_data;
      s1_mode  <= mode;
      s1_shift <= shift;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_lane
    activation_lane #(
      .IN_W    (IN_W),
      .OUT_W   (OUT_W),
      .SHIFT_W (SHIFT_W)
    ) u_lane (
      .x     (s1_data[k*IN_W +: IN_W]),
      .mode  (s1_mode),
      .shift (s1_shift),
      .y     (lane_y[k]),
      .sat   (lane_sat[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= lane_y;
        out_sat  <= lane_sat;
      end
    end
  end

  always_comb begin
    sat_pop = '0;
    for (int k = 0; k < CH; k++) begin
      sat_pop = sat_pop + POP_W'(out_sat[k]);
    end
    cnt_sum = {1'b0, sat_count} + (CNT_W+1)'(sat_pop);
  end

  // Clear outranks a same-cycle handshake; the carry bit pins the counter at all-ones
  always_ff @(posedge clk) begin
    if (rst || clr_count) begin
      sat_count <= '0;
    end else if (out_valid && out_ready) begin
      sat_count <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

endmodule
